// File: rtl/prng_pkg.sv
// Shared definitions for the 10-bit Galois LFSR (x^10 + x^3 + 1) family:
// word width, checker FSM states and the single-step next-word function.
package prng_pkg;

    localparam int LFSR_W = 10;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    // One Galois step: the output bit feeds back into bit 9 and taps bit 6.
    function automatic logic [LFSR_W-1:0] lfsr10_next(input logic [LFSR_W-1:0] s);
        return {s[0], s[9:8], s[7] ^ s[0], s[6:1]};
    endfunction

endpackage

// File: rtl/prng_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
// The count sticks at all-ones rather than wrapping back to zero.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear wins over increment; increment stops once the counter is full.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prng_checker.sv
// Receive-side checker for the 10-bit LFSR word stream. It seeds itself from
// the first nonzero word, confirms a run of correct predictions before
// declaring lock, then free-runs its prediction so isolated bit errors are
// counted without disturbing alignment. Lock is dropped after a run of
// consecutive mispredictions.
module prng_checker
    import prng_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clear,
    input  logic              In_Valid,
    input  logic [LFSR_W-1:0] In_Data,
    output logic              Locked,
    output logic              Err_Pulse,
    output logic              Sync_Loss,
    output logic [CNT_W-1:0]  Err_Count,
    output logic [CNT_W-1:0]  Word_Count
);

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_RUN = 4'(LOSS_COUNT);

    state_t            state;
    logic [LFSR_W-1:0] pred;
    logic [3:0]        run;
    logic [3:0]        run_next;
    logic              word_hit;
    logic              err_hit;

    assign run_next = run + 4'd1;
    assign word_hit = In_Valid && (state == LOCKED);
    assign err_hit  = word_hit && (In_Data != pred);
    assign Locked   = (state == LOCKED);

    // Hunt/verify/locked sequencing plus the prediction register and run length.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= HUNT;
            pred      <= '0;
            run       <= '0;
            Err_Pulse <= 1'b0;
            Sync_Loss <= 1'b0;
        end else begin
            Err_Pulse <= 1'b0;
            Sync_Loss <= 1'b0;
            if (In_Valid) begin
                case (state)
                    HUNT: begin
                        if (In_Data != '0) begin
                            pred  <= lfsr10_next(In_Data);
                            run   <= '0;
                            state <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (In_Data == pred) begin
                            pred <= lfsr10_next(pred);
                            if (run_next == LOCK_RUN) begin
                                run   <= '0;
                                state <= LOCKED;
                            end else begin
                                run <= run_next;
                            end
                        end else if (In_Data != '0) begin
                            pred <= lfsr10_next(In_Data);
                            run  <= '0;
                        end else begin
                            run   <= '0;
                            state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        pred <= lfsr10_next(pred);
                        if (In_Data == pred) begin
                            run <= '0;
                        end else begin
                            Err_Pulse <= 1'b1;
                            if (run_next == LOSS_RUN) begin
                                Sync_Loss <= 1'b1;
                                run       <= '0;
                                state     <= HUNT;
                            end else begin
                                run <= run_next;
                            end
                        end
                    end
                    default: begin
                        run   <= '0;
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_count (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (err_hit),
        .clr   (Clear),
        .count (Err_Count)
    );

    sat_counter #(.W(CNT_W)) u_word_count (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (word_hit),
        .clr   (Clear),
        .count (Word_Count)
    );

endmodule

// File: tb/tb_prng_checker.sv
// Self-checking bench for prng_checker, built with 4-bit counters so that
// saturation is reachable in a short run.
module tb_prng_checker;

    localparam int LOCK_COUNT = 4;
    localparam int LOSS_COUNT = 3;
    localparam int CNT_W      = 4;
    localparam int MAXC       = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Clear;
    logic             In_Valid;
    logic [9:0]       In_Data;
    logic             Locked;
    logic             Err_Pulse;
    logic             Sync_Loss;
    logic [CNT_W-1:0] Err_Count;
    logic [CNT_W-1:0] Word_Count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: 0 = hunting, 1 = verifying, 2 = locked
    int m_mode, m_pred, m_run, m_err, m_words;
    bit m_pulse, m_loss;
    int tx;

    prng_checker #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_COUNT (LOSS_COUNT),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Clear      (Clear),
        .In_Valid   (In_Valid),
        .In_Data    (In_Data),
        .Locked     (Locked),
        .Err_Pulse  (Err_Pulse),
        .Sync_Loss  (Sync_Loss),
        .Err_Count  (Err_Count),
        .Word_Count (Word_Count)
    );

    always #5 Clk = ~Clk;

    // Galois step as shift-and-conditional-xor of the tap mask
    function automatic int model_next(input int s);
        return (s >> 1) ^ (((s & 1) != 0) ? 'h240 : 0);
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= MAXC) ? MAXC : c + 1;
    endfunction

    function automatic logic [10:0] observed();
        return {Locked, Err_Pulse, Sync_Loss, Err_Count, Word_Count};
    endfunction

    function automatic logic [10:0] expected();
        return {(m_mode == 2), m_pulse, m_loss, 4'(m_err), 4'(m_words)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pred = 0; m_run = 0; m_err = 0; m_words = 0;
        m_pulse = 0; m_loss = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        bit bad;
        m_pulse = 0;
        m_loss  = 0;
        if (v) begin
            case (m_mode)
                0: if (d != 0) begin
                       m_pred = model_next(d); m_run = 0; m_mode = 1;
                   end
                1: if (d == m_pred) begin
                       m_pred = model_next(m_pred);
                       m_run++;
                       if (m_run == LOCK_COUNT) begin m_mode = 2; m_run = 0; end
                   end else if (d != 0) begin
                       m_pred = model_next(d); m_run = 0;
                   end else begin
                       m_mode = 0; m_run = 0;
                   end
                default: begin
                    bad     = (d != m_pred);
                    m_pred  = model_next(m_pred);
                    m_words = sat_inc(m_words);
                    if (bad) begin
                        m_pulse = 1;
                        m_err   = sat_inc(m_err);
                        m_run++;
                        if (m_run == LOSS_COUNT) begin
                            m_loss = 1; m_mode = 0; m_run = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            endcase
        end
        if (c) begin
            m_err   = 0;
            m_words = 0;
        end
    endtask

    // Called at posedge+1; applies inputs for one clock and samples at the next posedge+1
    task automatic drive(input bit v, input int d, input bit c);
        In_Valid = v;
        In_Data  = 10'(d);
        Clear    = c;
        @(posedge Clk);
        model_step(v, d, c);
        #1;
    endtask

    // Sends the next true-sequence word, optionally xor-corrupted
    task automatic send_tx(input int mask);
        drive(1'b1, tx ^ mask, 1'b0);
        tx = model_next(tx);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Clear = 1'b0; In_Valid = 1'b0; In_Data = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (observed() !== expected()) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %h, expected %h", observed(), expected());
        end
        Reset = 1'b0;
    endtask

    task automatic test_lock();
        tx = 'h001;
        for (int i = 0; i < 8; i++) begin
            send_tx(0);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL lock_seq[%0d]: got %h, expected %h", i, observed(), expected());
            end
            if (i == 4) begin
                n_checks++;
                if (Locked !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL lock_latency: got Locked=%b, expected 1", Locked);
                end
            end
        end
    endtask

    task automatic test_single_error();
        for (int i = 0; i < 6; i++) begin
            send_tx((i == 1) ? 'h008 : 0);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL single_err[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (Err_Count !== 4'd1 || Locked !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_err_count: got err=%0d locked=%b, expected 1 and 1",
                     Err_Count, Locked);
        end
    endtask

    task automatic test_sync_loss();
        for (int i = 0; i < 3; i++) begin
            send_tx($urandom_range(1, 1023));
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL loss_burst[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (Sync_Loss !== 1'b1 || Err_Pulse !== 1'b1 || Locked !== 1'b0 || Err_Count !== 4'd4) begin
            n_fail++;
            $display("[TB] FAIL loss_event: got loss=%b pulse=%b locked=%b err=%0d, expected 1 1 0 4",
                     Sync_Loss, Err_Pulse, Locked, Err_Count);
        end
        for (int i = 0; i < 5; i++) begin
            send_tx(0);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL relock[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (Locked !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL relock_latency: got Locked=%b, expected 1", Locked);
        end
    endtask

    task automatic test_hunt_zeros();
        In_Valid = 1'b0;
        Reset = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 0, 1'b0);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL hunt_zero[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
        tx = 'h001;
        send_tx(0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, $urandom_range(0, 1023), 1'b0);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL hunt_idle[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
        for (int i = 0; i < 4; i++) begin
            send_tx(0);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL gap_lock[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (Locked !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gap_lock_latency: got Locked=%b, expected 1", Locked);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 36; i++) begin
            send_tx(((i % 2) == 0) ? (1 << $urandom_range(0, 9)) : 0);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL sat[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (Err_Count !== 4'hF || Word_Count !== 4'hF) begin
            n_fail++;
            $display("[TB] FAIL sat_hold: got err=%0d words=%0d, expected 15 15", Err_Count, Word_Count);
        end
        drive(1'b1, tx ^ 'h100, 1'b1);
        tx = model_next(tx);
        n_checks++;
        if (Err_Count !== 4'd0 || Word_Count !== 4'd0 || Err_Pulse !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_prio: got err=%0d words=%0d pulse=%b, expected 0 0 1",
                     Err_Count, Word_Count, Err_Pulse);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) send_tx(0);
        In_Valid = 1'b0;
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (observed() !== expected()) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h, expected %h", observed(), expected());
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_tx(0);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL post_reset[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (Locked !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_lock: got Locked=%b, expected 1", Locked);
        end
    endtask

    task automatic test_random();
        bit v, c;
        int r, d;
        tx = $urandom_range(1, 1023);
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 31) == 0);
            r = $urandom_range(0, 15);
            if (r == 0)      d = 0;
            else if (r <= 2) d = tx ^ (1 << $urandom_range(0, 9));
            else             d = tx;
            drive(v, d, c);
            if (v) tx = model_next(tx);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: got %h, expected %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_sync_loss();
        test_hunt_zeros();
        test_saturation();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prng_checker.md
Name: prng_checker

Overview:
- Receive end of the 10-bit Galois LFSR stream (polynomial x^10 + x^3 + 1) used by the hardware PRNG.
- Self-synchronises to an incoming word stream and predicts each next word. Reports lock status, error pulses and saturating error/word counts.
- Sits downstream of any PRNG/LFSR source, or after a link carrying its words. Used for board bring-up and in-system BIST.

Parameters:
- LOCK_COUNT, 4, consecutive correct predictions needed in VERIFY to declare lock (1..15)
- LOSS_COUNT, 3, consecutive mispredictions in LOCKED that drop lock (1..15)
- CNT_W, 16, width of Err_Count and Word_Count

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- Clear  in  1  synchronous; zeroes Err_Count and Word_Count only
- In_Valid  in  1  In_Data valid this cycle; one word accepted per valid cycle, no backpressure
- In_Data  in  10  received LFSR word
- Locked  out  1  high while FSM in LOCKED
- Err_Pulse  out  1  one-cycle pulse per mispredicted word while LOCKED
- Sync_Loss  out  1  one-cycle pulse on LOCKED -> HUNT transition
- Err_Count  out  CNT_W  saturating count of mispredicted words while LOCKED
- Word_Count  out  CNT_W  saturating count of words accepted while LOCKED (good and bad)

Behaviour:
- Step function: next(s) = {s[0], s[9:8], s[7]^s[0], s[6:1]}. Example sequence: 0x001 -> 0x240 -> 0x120 -> 0x090.
- Registers: state, pred[9:0], run counter (4b), Err_Count, Word_Count, Err_Pulse, Sync_Loss.
- Reset values: state=HUNT, pred=0, run=0, Locked=0, Err_Pulse=0, Sync_Loss=0, both counts=0.
- All outputs are registered. Response appears the cycle after the accepted word. Cycles with In_Valid=0 change nothing except clearing pulses.
- HUNT, on a valid word w:
  - w==0: ignore (lock-up word), stay in HUNT.
  - otherwise: pred<=next(w), run<=0, go to VERIFY.
- VERIFY, on a valid word w:
  - w==pred: pred<=next(pred), run++. If run reaches LOCK_COUNT, go to LOCKED with run<=0.
  - w!=pred and w!=0: reseed with pred<=next(w), run<=0, stay in VERIFY.
  - w==0: go to HUNT.
- LOCKED, on a valid word w:
  - pred<=next(pred) always; never reseed from received data, so a single bit error does not derail the prediction.
  - Word_Count++ on every word.
  - w==pred: run<=0.
  - w!=pred: Err_Pulse=1, Err_Count++, run++. If run reaches LOSS_COUNT: Sync_Loss=1, go to HUNT, run<=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Clear priority: when Clear coincides with a counted word, both counts become 0 (that word is not counted). Err_Pulse and Sync_Loss still fire. FSM and pred are unaffected by Clear.
- Lock latency: seed word plus LOCK_COUNT matching words. Locked rises the cycle after the (LOCK_COUNT+1)th word.
- Reset mid-stream: immediate return to HUNT; the next nonzero word reseeds.
- Sync_Loss and Err_Pulse coincide on the final losing word. Locked falls the same cycle.

Decomposition:
- prng_pkg:
  - state enum {HUNT, VERIFY, LOCKED}
  - function lfsr10_next(s)
  - localparam LFSR_W=10
  - lfsr10_next is shared with future generator blocks.
- One sub-module, sat_counter (parameter W): inputs inc and clr, clr has priority, saturates at all-ones. Instantiated twice, for Err_Count and Word_Count.

Test Plan:
1. Reset; stream 0x001, 0x240, 0x120, 0x090, 0x048 (continue true sequence), one word per cycle -> Locked=1 the cycle after 0x048. Counts 0 until the first LOCKED word, then Word_Count increments per word.
2. Locked on the true sequence; corrupt one word (flip bit 3), then resume the true sequence -> exactly one Err_Pulse, Err_Count=1, Locked stays 1, subsequent words match.
3. Locked; feed 3 consecutive wrong words -> Err_Count=3, Sync_Loss pulse on the 3rd, Locked=0. Then a nonzero word reseeds and lock is reacquired after 4 further matches.
4. In HUNT, feed 0x000 repeatedly, then 0x001, 0x240 with a gap of 5 idle cycles (In_Valid=0) -> zeros ignored, idle cycles leave state unchanged, VERIFY run reaches 1.
5. Force Err_Count near 2^16-1 via long error bursts (or CNT_W=4 build) -> count holds at max. Clear asserted together with an error word -> counts read 0 and Err_Pulse=1.
6. Assert Reset while LOCKED mid-stream -> all outputs 0 asynchronously. After release, lock is reacquired after 5 valid words.
